// File: rtl/bcd_serial_converter.sv
// Sequential binary-to-BCD converter using the double-dabble algorithm,
// one shift-and-adjust iteration per clock, with a valid/ready handshake on each side.
module bcd_serial_converter #(
    parameter int N = 8,
    localparam int W = N + (N - 4) / 3 + 1,
    localparam int D = (W + 3) / 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         i_clk,
    input  logic         i_areset,
    input  logic [N-1:0] i_bin,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_bcd,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_busy
);

    if (N < 4) begin : g_bad_n
        $error("bcd_serial_converter: N must be at least 4");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          state, state_nxt;
    logic [N-1:0]    sr, sr_nxt;
    logic [D*4-1:0]  dig, dig_adj, dig_nxt;
    logic [CW-1:0]   cnt;

    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d > 4'd4) ? d + 4'd3 : d;
    endfunction

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_busy    = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                o_busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // All digits are adjusted from their pre-iteration values before the joint shift.
    always_comb begin
        dig_adj = '0;
        for (int i = 0; i < D; i++) begin
            dig_adj[4*i +: 4] = dabble_adj(dig[4*i +: 4]);
        end
        dig_nxt = {dig_adj[D*4-2:0], sr[N-1]};
        sr_nxt  = {sr[N-2:0], 1'b0};
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            sr    <= '0;
            dig   <= '0;
            cnt   <= '0;
            o_bcd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        sr  <= i_bin;
                        dig <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sr  <= sr_nxt;
                    dig <= dig_nxt;
                    cnt <= cnt + CW'(1);
                    // Upper digit bits beyond W can never be set, so only W bits are kept.
                    if (cnt == LAST) o_bcd <= dig_nxt[W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Directed bench for bcd_serial_converter: N=8 and N=12 instances, latency,
// backpressure, async reset, back-to-back throughput and an exhaustive 8-bit sweep.
module tb_bcd_serial_converter;

    logic        clk = 1'b0;
    logic        areset;
    logic [7:0]  bin8;
    logic        i_valid8, i_ready8;
    logic        o_ready8, o_valid8, o_busy8;
    logic [9:0]  bcd8;
    logic [11:0] bin12;
    logic        i_valid12, i_ready12;
    logic        o_ready12, o_valid12, o_busy12;
    logic [14:0] bcd12;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bcd_serial_converter #(.N(8)) dut8 (
        .i_clk(clk), .i_areset(areset), .i_bin(bin8), .i_valid(i_valid8),
        .o_ready(o_ready8), .o_bcd(bcd8), .o_valid(o_valid8),
        .i_ready(i_ready8), .o_busy(o_busy8)
    );

    bcd_serial_converter #(.N(12)) dut12 (
        .i_clk(clk), .i_areset(areset), .i_bin(bin12), .i_valid(i_valid12),
        .o_ready(o_ready12), .o_bcd(bcd12), .o_valid(o_valid12),
        .i_ready(i_ready12), .o_busy(o_busy12)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dec_ref(input int v);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] b);
        chk("rdy_before_send", 32'(o_ready8), 32'd1);
        bin8 = b;
        i_valid8 = 1'b1;
        tick();
        i_valid8 = 1'b0;
    endtask

    // Called in the first cycle after the accept edge; lat counts cycles since accept.
    task automatic wait_valid8(output int lat);
        lat = 1;
        while (o_valid8 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int c_v1, c_b2, c_v2;
        logic [31:0] r1, r2;
        logic seen_v1, seen_idle;

        areset = 1'b1;
        bin8 = '0; i_valid8 = 1'b0; i_ready8 = 1'b0;
        bin12 = '0; i_valid12 = 1'b0; i_ready12 = 1'b0;
        #3;
        chk("rst_ready8", 32'(o_ready8), 32'd1);
        chk("rst_valid8", 32'(o_valid8), 32'd0);
        chk("rst_busy8",  32'(o_busy8),  32'd0);
        chk("rst_bcd8",   32'(bcd8),     32'd0);
        chk("rst_ready12", 32'(o_ready12), 32'd1);
        chk("rst_bcd12",   32'(bcd12),     32'd0);
        @(negedge clk);
        areset = 1'b0;
        tick();

        // Zero input, downstream always ready
        i_ready8 = 1'b1;
        send8(8'd0);
        chk("zero_busy", 32'(o_busy8), 32'd1);
        wait_valid8(lat);
        chk("zero_lat", 32'(lat), 32'd9);
        chk("zero_bcd", 32'(bcd8), 32'h000);
        tick();

        // Full-scale input, o_ready returns the cycle after the handshake
        send8(8'd255);
        wait_valid8(lat);
        chk("ff_lat", 32'(lat), 32'd9);
        chk("ff_bcd", 32'(bcd8), 32'h255);
        tick();
        chk("ff_ready_after", 32'(o_ready8), 32'd1);
        chk("ff_valid_after", 32'(o_valid8), 32'd0);

        // Backpressure: result held while inputs wiggle
        i_ready8 = 1'b0;
        send8(8'd99);
        wait_valid8(lat);
        chk("bp_lat", 32'(lat), 32'd9);
        for (int i = 0; i < 20; i++) begin
            bin8 = 8'($urandom);
            i_valid8 = 1'($urandom);
            chk("bp_valid", 32'(o_valid8), 32'd1);
            chk("bp_bcd",   32'(bcd8),     32'h099);
            chk("bp_ready", 32'(o_ready8), 32'd0);
            tick();
        end
        chk("bp_bcd_end", 32'(bcd8), 32'h099);
        // Request held high through the handshake edge must not be taken there
        bin8 = 8'd5;
        i_valid8 = 1'b1;
        i_ready8 = 1'b1;
        tick();
        chk("hs_ready", 32'(o_ready8), 32'd1);
        chk("hs_busy",  32'(o_busy8),  32'd0);
        chk("hs_valid", 32'(o_valid8), 32'd0);
        chk("hs_bcd_hold", 32'(bcd8), 32'h099);
        tick();
        i_valid8 = 1'b0;
        chk("after_hs_busy", 32'(o_busy8), 32'd1);
        bin8 = 8'd77;
        wait_valid8(lat);
        chk("five_lat", 32'(lat), 32'd9);
        chk("five_bcd", 32'(bcd8), 32'h005);
        tick();

        // Asynchronous reset in the 4th SHIFT cycle, then immediate new request
        send8(8'd200);
        tick(); tick(); tick();
        chk("mid_busy", 32'(o_busy8), 32'd1);
        #2 areset = 1'b1;
        #1;
        chk("arst_bcd",   32'(bcd8),     32'd0);
        chk("arst_valid", 32'(o_valid8), 32'd0);
        chk("arst_ready", 32'(o_ready8), 32'd1);
        chk("arst_busy",  32'(o_busy8),  32'd0);
        bin8 = 8'd37;
        i_valid8 = 1'b1;
        #2 areset = 1'b0;
        tick();
        i_valid8 = 1'b0;
        chk("post_rst_accept", 32'(o_busy8), 32'd1);
        wait_valid8(lat);
        chk("post_rst_lat", 32'(lat), 32'd9);
        chk("post_rst_bcd", 32'(bcd8), 32'h037);
        tick();

        // N=12 back-to-back
        i_ready12 = 1'b1;
        bin12 = 12'd4095;
        i_valid12 = 1'b1;
        tick();
        bin12 = 12'd1000;
        c_v1 = -1; c_b2 = -1; c_v2 = -1;
        r1 = '0; r2 = '0;
        seen_v1 = 1'b0; seen_idle = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (o_valid12 && !seen_v1) begin
                seen_v1 = 1'b1; c_v1 = c; r1 = 32'(bcd12);
            end else if (seen_v1 && !o_busy12 && !o_valid12) begin
                seen_idle = 1'b1;
            end else if (seen_idle && o_busy12 && c_b2 < 0) begin
                c_b2 = c; i_valid12 = 1'b0;
            end else if (c_b2 > 0 && o_valid12 && c_v2 < 0) begin
                c_v2 = c; r2 = 32'(bcd12);
            end
            tick();
        end
        i_valid12 = 1'b0;
        chk("n12_lat1", 32'(c_v1), 32'd13);
        chk("n12_bcd1", r1, 32'h4095);
        chk("n12_accept2", 32'(c_b2), 32'd15);
        chk("n12_lat2", 32'(c_v2), 32'd27);
        chk("n12_bcd2", r2, 32'h1000);

        // Exhaustive 8-bit sweep with random request and acceptance gaps
        for (int v = 0; v < 256; v++) begin
            repeat ($urandom_range(0, 2)) tick();
            i_ready8 = 1'($urandom);
            send8(8'(v));
            bin8 = 8'($urandom);
            wait_valid8(lat);
            chk("sweep_lat", 32'(lat), 32'd9);
            chk("sweep_bcd", 32'(bcd8), dec_ref(v));
            i_ready8 = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            chk("sweep_hold", 32'(o_valid8), 32'd1);
            i_ready8 = 1'b1;
            tick();
            i_ready8 = 1'b0;
            chk("sweep_drained", 32'(o_valid8), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
